defuzzy_centroide: RTL and testbench
====================================

DEFUZZY_CENTROIDE -- requirements
Module: defuzzy_centroide

Interface
REQ-001 The block SHALL have parameter N_REGRAS, default 9, giving the number of rule terms per evaluation.
REQ-002 The block SHALL have parameter W, default 8, giving the width of strengths, positions and output.
REQ-003 clk_0  in  1  single clock; all state changes on its rising edge.
REQ-004 Srst  in  1  reset; asynchronous, active-low.
REQ-005 inicio  in  1  one-cycle pulse that starts a new rule set.
REQ-006 regra_valida  in  1  the rule term on forca_up/forca_low/pos_consequente is valid this cycle.
REQ-007 forca_up  in  W  upper firing strength of the current rule.
REQ-008 forca_low  in  W  lower firing strength of the current rule.
REQ-009 pos_consequente  in  W  centroid position of the rule consequent.
REQ-010 saida_defuzzy  out  W  crisp output; held until the next result.
REQ-011 saida_valida  out  1  one-cycle pulse when saida_defuzzy is updated.
REQ-012 ocupado  out  1  high whenever the FSM is not in OCIOSO.
REQ-013 erro_zero  out  1  set with a result whose strength sum was zero; held until the next result.

Function
REQ-014 The FSM SHALL have states OCIOSO, ACUMULA, DIVIDE and SAIDA.
REQ-015 OCIOSO: inicio=1 SHALL clear the accumulators and the rule counter and go to ACUMULA.
REQ-016 ACUMULA: each regra_valida=1 SHALL add s=forca_up+forca_low (9 bits) to den (13 bits) and s*pos_consequente (17 bits) to num (21 bits), then increment the counter.
REQ-017 When the N_REGRAS-th term is sampled, the FSM SHALL go to DIVIDE if den!=0, else directly to SAIDA with result 0 and erro_zero=1.
REQ-018 inicio=1 in ACUMULA SHALL restart the set (clear, stay in ACUMULA), and takes precedence over a simultaneous regra_valida.
REQ-019 DIVIDE SHALL compute (num + den>>1) / den by a restoring division at 1 quotient bit per cycle, 21 cycles, rounding half-up.
REQ-020 The quotient SHALL saturate at 2^W-1.
REQ-021 SAIDA SHALL last one cycle: register saida_defuzzy and erro_zero, pulse saida_valida, then return to OCIOSO.
REQ-022 Latency: saida_valida SHALL be high in the cycle after the 22nd rising edge following the edge that sampled the last term (non-zero case), or after the 1st edge (zero case).
REQ-023 regra_valida outside ACUMULA, and inicio in DIVIDE or SAIDA, SHALL be ignored.
REQ-024 Accumulators SHALL not overflow for any input values (num max 1,170,450 < 2^21; den max 4,590 < 2^13).

Reset
REQ-025 Srst low SHALL immediately force state OCIOSO, saida_defuzzy=0, saida_valida=0, ocupado=0, erro_zero=0, and clear num, den, counter and divider registers.
REQ-026 Reset asserted mid-operation SHALL abandon the set with no saida_valida pulse; the first inicio after release SHALL operate normally.

Structure
REQ-027 A shared package defuzzy_pkg SHALL hold W, W_NUM=21, W_DEN=13, N_REGRAS default and the FSM state type.
REQ-028 The division SHALL be a sub-module divisor_serial (start/done handshake, 21-bit dividend, 13-bit divisor, 1 bit per cycle); the accumulators and FSM stay in defuzzy_centroide.

Verification
REQ-029 Nine terms up=low=255, pos=128 -> saida_defuzzy=128, erro_zero=0, saida_valida after 22 edges.
REQ-030 Nine terms all strengths 0 -> saida_defuzzy=0, erro_zero=1, saida_valida after 1 edge.
REQ-031 Term1 up=low=100 pos=0, term2 up=low=100 pos=255, seven terms zero -> 51200/400 = 128 (rounded up from 127.5).
REQ-032 Term up=200 low=100 pos=240, other eight zero -> 240.
REQ-033 inicio after 4 terms, then 9 terms up=low=255 pos=128 -> single result 128; regra_valida pulses during DIVIDE do not change it.
REQ-034 Srst low during DIVIDE -> all outputs 0 at once, no saida_valida pulse; the next full set produces the correct result.

Source files
------------

// File: rtl/defuzzy_pkg.sv
// Shared constants and FSM state type for the interval type-2 centroid defuzzifier.
package defuzzy_pkg;
  localparam int W               = 8;
  localparam int W_NUM           = 21;
  localparam int W_DEN           = 13;
  localparam int N_REGRAS_PADRAO = 9;

  typedef enum logic [1:0] {
    OCIOSO,
    ACUMULA,
    DIVIDE,
    SAIDA
  } estado_t;
endpackage

// File: rtl/divisor_serial.sv
// Restoring divider, one quotient bit per clock; the start edge already produces the MSB.
module divisor_serial (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [defuzzy_pkg::W_NUM-1:0]  i_dividendo,
  input  logic [defuzzy_pkg::W_DEN-1:0]  i_divisor,
  output logic                           o_done,
  output logic [defuzzy_pkg::W_NUM-1:0]  o_quociente
);
  import defuzzy_pkg::*;

  localparam int W_CNT = $clog2(W_NUM);

  typedef struct packed {
    logic [W_DEN-1:0] resto;
    logic [W_NUM-1:0] quoc;
  } passo_t;

  logic [W_DEN-1:0] r_resto;
  logic [W_NUM-1:0] r_quoc;
  logic [W_DEN-1:0] r_div;
  logic [W_CNT-1:0] r_cnt;
  logic             r_ativo;
  logic             r_done;
  passo_t           w_passo_ini;
  passo_t           w_passo;

  function automatic passo_t passo(input logic [W_DEN-1:0] resto,
                                   input logic [W_NUM-1:0] quoc,
                                   input logic [W_DEN-1:0] div);
    logic [W_DEN:0]   desloc;
    logic [W_DEN+1:0] teste;
    passo_t           r;
    desloc = {resto, quoc[W_NUM-1]};
    teste  = {1'b0, desloc} - {2'b00, div};
    // Borrow out of the trial subtraction means the divisor did not fit.
    if (teste[W_DEN+1]) r.resto = desloc[W_DEN-1:0];
    else                r.resto = teste[W_DEN-1:0];
    r.quoc = {quoc[W_NUM-2:0], ~teste[W_DEN+1]};
    return r;
  endfunction

  assign w_passo_ini = passo('0, i_dividendo, i_divisor);
  assign w_passo     = passo(r_resto, r_quoc, r_div);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resto <= '0;
      r_quoc  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_ativo <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_start) begin
      r_resto <= w_passo_ini.resto;
      r_quoc  <= w_passo_ini.quoc;
      r_div   <= i_divisor;
      r_cnt   <= W_CNT'(W_NUM - 1);
      r_ativo <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_ativo) begin
      r_resto <= w_passo.resto;
      r_quoc  <= w_passo.quoc;
      r_cnt   <= r_cnt - W_CNT'(1);
      if (r_cnt == W_CNT'(1)) begin
        r_ativo <= 1'b0;
        r_done  <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done      = r_done;
  assign o_quociente = r_quoc;
endmodule

// File: rtl/defuzzy_centroide.sv
// Centroid defuzzifier: accumulates (up+low) and (up+low)*pos over N_REGRAS terms, then divides.
module defuzzy_centroide #(
  parameter int N_REGRAS = defuzzy_pkg::N_REGRAS_PADRAO,
  parameter int W        = defuzzy_pkg::W
) (
  input  logic         clk_0,
  input  logic         Srst,
  input  logic         inicio,
  input  logic         regra_valida,
  input  logic [W-1:0] forca_up,
  input  logic [W-1:0] forca_low,
  input  logic [W-1:0] pos_consequente,
  output logic [W-1:0] saida_defuzzy,
  output logic         saida_valida,
  output logic         ocupado,
  output logic         erro_zero
);
  import defuzzy_pkg::*;

  localparam int W_CNT = $clog2(N_REGRAS + 1);

  estado_t          r_estado;
  logic [W_NUM-1:0] r_num;
  logic [W_DEN-1:0] r_den;
  logic [W_CNT-1:0] r_cnt;
  logic [W-1:0]     r_saida;
  logic             r_valida;
  logic             r_ocupado;
  logic             r_erro;

  logic [W:0]       w_soma;
  logic [W_NUM-1:0] w_num_prox;
  logic [W_DEN-1:0] w_den_prox;
  logic             w_ultimo;
  logic             w_aceita;
  logic             w_start;
  logic             w_done;
  logic [W_NUM-1:0] w_quoc;
  logic [W-1:0]     w_quoc_sat;

  assign w_soma     = {1'b0, forca_up} + {1'b0, forca_low};
  assign w_num_prox = r_num + W_NUM'(w_soma) * W_NUM'(pos_consequente);
  assign w_den_prox = r_den + W_DEN'(w_soma);
  assign w_ultimo   = (r_cnt == W_CNT'(N_REGRAS - 1));
  assign w_aceita   = (r_estado == ACUMULA) && !inicio && regra_valida;
  // Divider is launched on the same edge that absorbs the last term, using the updated sums.
  assign w_start    = w_aceita && w_ultimo && (w_den_prox != '0);
  assign w_quoc_sat = (w_quoc > W_NUM'((2 ** W) - 1)) ? '1 : w_quoc[W-1:0];

  divisor_serial u_divisor (
    .clk         (clk_0),
    .rst_n       (Srst),
    .i_start     (w_start),
    .i_dividendo (w_num_prox + W_NUM'(w_den_prox >> 1)),
    .i_divisor   (w_den_prox),
    .o_done      (w_done),
    .o_quociente (w_quoc)
  );

  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      r_estado  <= OCIOSO;
      r_num     <= '0;
      r_den     <= '0;
      r_cnt     <= '0;
      r_saida   <= '0;
      r_valida  <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_valida <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            r_num     <= '0;
            r_den     <= '0;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
            r_estado  <= ACUMULA;
          end
        end
        ACUMULA: begin
          if (inicio) begin
            r_num <= '0;
            r_den <= '0;
            r_cnt <= '0;
          end else if (regra_valida) begin
            r_num <= w_num_prox;
            r_den <= w_den_prox;
            r_cnt <= r_cnt + W_CNT'(1);
            if (w_ultimo) r_estado <= (w_den_prox != '0) ? DIVIDE : SAIDA;
          end
        end
        DIVIDE: begin
          if (w_done) r_estado <= SAIDA;
        end
        SAIDA: begin
          r_valida  <= 1'b1;
          r_ocupado <= 1'b0;
          r_estado  <= OCIOSO;
          if (r_den == '0) begin
            r_saida <= '0;
            r_erro  <= 1'b1;
          end else begin
            r_saida <= w_quoc_sat;
            r_erro  <= 1'b0;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign saida_defuzzy = r_saida;
  assign saida_valida  = r_valida;
  assign ocupado       = r_ocupado;
  assign erro_zero     = r_erro;
endmodule

// File: tb/tb_defuzzy_centroide.sv
// Scoreboard bench for defuzzy_centroide: expected results queued at stimulus time, popped on saida_valida.
module tb_defuzzy_centroide;
  logic       clk_0 = 1'b0;
  logic       Srst = 1'b1;
  logic       inicio = 1'b0;
  logic       regra_valida = 1'b0;
  logic [7:0] forca_up = '0;
  logic [7:0] forca_low = '0;
  logic [7:0] pos_consequente = '0;
  logic [7:0] saida_defuzzy;
  logic       saida_valida;
  logic       ocupado;
  logic       erro_zero;

  typedef struct {
    int val;
    int erro;
    int ciclo;
  } esperado_t;

  esperado_t fila[$];
  int n_checks = 0;
  int n_ok = 0;
  int ciclo = 0;
  int t_up[9];
  int t_low[9];
  int t_pos[9];

  defuzzy_centroide #(.N_REGRAS(9), .W(8)) dut (
    .clk_0           (clk_0),
    .Srst            (Srst),
    .inicio          (inicio),
    .regra_valida    (regra_valida),
    .forca_up        (forca_up),
    .forca_low       (forca_low),
    .pos_consequente (pos_consequente),
    .saida_defuzzy   (saida_defuzzy),
    .saida_valida    (saida_valida),
    .ocupado         (ocupado),
    .erro_zero       (erro_zero)
  );

  always #5 clk_0 = ~clk_0;
  always @(posedge clk_0) ciclo <= ciclo + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Monitor: each output pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk_0) begin
    if (saida_valida) begin
      if (fila.size() == 0) begin
        check("valida_inesperado", 1, 0);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        check("saida_defuzzy", int'(saida_defuzzy), e.val);
        check("erro_zero", int'(erro_zero), e.erro);
        check("latencia", ciclo, e.ciclo);
      end
    end
  end

  task automatic ocioso(input int n);
    repeat (n) begin
      @(posedge clk_0);
      #1;
    end
  endtask

  task automatic pulso_inicio(input bit com_regra);
    inicio = 1'b1;
    regra_valida = com_regra;
    forca_up = 8'd255;
    forca_low = 8'd255;
    pos_consequente = 8'd255;
    @(posedge clk_0);
    #1;
    inicio = 1'b0;
    regra_valida = 1'b0;
  endtask

  task automatic termo(input int up, input int low, input int pos);
    forca_up = 8'(up);
    forca_low = 8'(low);
    pos_consequente = 8'(pos);
    regra_valida = 1'b1;
    @(posedge clk_0);
    #1;
    regra_valida = 1'b0;
  endtask

  task automatic preenche(input int up, input int low, input int pos);
    for (int i = 0; i < 9; i++) begin
      t_up[i] = up;
      t_low[i] = low;
      t_pos[i] = pos;
    end
  endtask

  // Drives one full rule set from t_up/t_low/t_pos and queues the reference result.
  task automatic roda_conjunto(input int lacuna_max, input bit com_regra, input bit ruido);
    longint num = 0;
    longint den = 0;
    esperado_t e;
    pulso_inicio(com_regra);
    for (int i = 0; i < 9; i++) begin
      ocioso(int'($urandom_range(lacuna_max, 0)));
      termo(t_up[i], t_low[i], t_pos[i]);
      num += longint'(t_up[i] + t_low[i]) * t_pos[i];
      den += t_up[i] + t_low[i];
    end
    if (den == 0) begin
      e.val = 0;
      e.erro = 1;
      e.ciclo = ciclo + 1;
    end else begin
      e.val = int'((num + den / 2) / den);
      if (e.val > 255) e.val = 255;
      e.erro = 0;
      e.ciclo = ciclo + 22;
    end
    fila.push_back(e);
    if (ruido) begin
      for (int k = 0; k < 5; k++) begin
        forca_up = 8'd255;
        forca_low = 8'd255;
        pos_consequente = 8'd0;
        regra_valida = 1'b1;
        inicio = (k == 2);
        @(posedge clk_0);
        #1;
      end
      regra_valida = 1'b0;
      inicio = 1'b0;
      check("ocupado_divide", int'(ocupado), 1);
    end
  endtask

  task automatic aguarda();
    int n = 0;
    while (fila.size() != 0 && n < 60) begin
      @(posedge clk_0);
      #1;
      n++;
    end
    check("fila_no_prazo", fila.size(), 0);
    ocioso(2);
    check("ocupado_ocioso", int'(ocupado), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2 Srst = 1'b0;
    #1;
    check("reset_saida", int'(saida_defuzzy), 0);
    check("reset_valida", int'(saida_valida), 0);
    check("reset_ocupado", int'(ocupado), 0);
    check("reset_erro", int'(erro_zero), 0);
    ocioso(2);
    Srst = 1'b1;
    ocioso(2);

    preenche(255, 255, 128);
    roda_conjunto(0, 1'b0, 1'b0);
    aguarda();

    preenche(0, 0, 77);
    roda_conjunto(0, 1'b0, 1'b0);
    aguarda();
    ocioso(3);
    check("erro_retido", int'(erro_zero), 1);
    check("saida_retida", int'(saida_defuzzy), 0);

    preenche(0, 0, 0);
    t_up[0] = 100; t_low[0] = 100; t_pos[0] = 0;
    t_up[1] = 100; t_low[1] = 100; t_pos[1] = 255;
    roda_conjunto(1, 1'b0, 1'b0);
    aguarda();

    preenche(0, 0, 0);
    t_up[4] = 200; t_low[4] = 100; t_pos[4] = 240;
    roda_conjunto(0, 1'b0, 1'b0);
    aguarda();

    preenche(255, 0, 255);
    roda_conjunto(0, 1'b0, 1'b0);
    aguarda();

    pulso_inicio(1'b0);
    for (int i = 0; i < 4; i++) termo(200, 17, 3);
    preenche(255, 255, 128);
    roda_conjunto(0, 1'b1, 1'b1);
    aguarda();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 9; i++) begin
        t_up[i] = int'($urandom_range(255, 0));
        t_low[i] = int'($urandom_range(255, 0));
        t_pos[i] = int'($urandom_range(255, 0));
      end
      roda_conjunto(2, 1'b0, 1'b0);
      aguarda();
    end

    preenche(255, 255, 128);
    roda_conjunto(0, 1'b0, 1'b0);
    aguarda();
    pulso_inicio(1'b0);
    for (int i = 0; i < 9; i++) termo(200, 200, 50);
    ocioso(5);
    Srst = 1'b0;
    #1;
    check("rst_divide_saida", int'(saida_defuzzy), 0);
    check("rst_divide_valida", int'(saida_valida), 0);
    check("rst_divide_ocupado", int'(ocupado), 0);
    check("rst_divide_erro", int'(erro_zero), 0);
    ocioso(2);
    Srst = 1'b1;
    ocioso(30);
    check("rst_sem_resultado", fila.size(), 0);

    preenche(0, 0, 0);
    t_up[0] = 100; t_low[0] = 100; t_pos[0] = 0;
    t_up[1] = 100; t_low[1] = 100; t_pos[1] = 255;
    roda_conjunto(0, 1'b0, 1'b0);
    aguarda();

    check("fila_vazia", fila.size(), 0);
    $display("%0d/%0d checks passed", n_ok, n_checks);
    $finish;
  end
endmodule
